// File: rtl/timer_sched_ctrl_pkg.sv
// timer_sched_ctrl_pkg
// Shared definitions for the timer scheduling controller.
// Contents:
//   state_e        - controller FSM states
//   TM_ADDR_*      - halfword register addresses of the timer slave
//   CTRL_*_BIT     - bit positions inside the timer control register
//   CMD_STOP/START - control words written to stop and arm the timer
//   tm_access_t    - one timer bus access (select, address, data)
//   tm_access_for  - maps a controller state to the access it performs
package timer_sched_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_STOP,
      ST_P0,
      ST_P1,
      ST_P2,
      ST_P3,
      ST_START,
      ST_WAIT,
      ST_CLEAR,
      ST_DONE
   } state_e;

   localparam logic [3:0] TM_ADDR_STATUS  = 4'd0;
   localparam logic [3:0] TM_ADDR_CONTROL = 4'd1;
   localparam logic [3:0] TM_ADDR_PERIOD0 = 4'd2;
   localparam logic [3:0] TM_ADDR_PERIOD1 = 4'd3;
   localparam logic [3:0] TM_ADDR_PERIOD2 = 4'd4;
   localparam logic [3:0] TM_ADDR_PERIOD3 = 4'd5;

   localparam int CTRL_ITO_BIT   = 0;
   localparam int CTRL_CONT_BIT  = 1;
   localparam int CTRL_START_BIT = 2;
   localparam int CTRL_STOP_BIT  = 3;

   localparam logic [15:0] CMD_STOP = 16'(1 << CTRL_STOP_BIT);

   // One-shot arm: CONT is explicitly kept clear so the timer fires once.
   localparam logic [15:0] CMD_START =
      16'((1 << CTRL_START_BIT) | (1 << CTRL_ITO_BIT)) & ~16'(1 << CTRL_CONT_BIT);

   typedef struct packed {
      logic        cs;
      logic [3:0]  addr;
      logic [15:0] data;
   } tm_access_t;

   localparam tm_access_t TM_NO_ACCESS = '{cs: 1'b0, addr: 4'd0, data: 16'd0};

   // The upper two period halfwords are always zero: periods are 32 bits wide
   // while the timer counter is 64 bits wide.
   function automatic tm_access_t tm_access_for(input state_e st, input logic [31:0] period);
      tm_access_t acc;
      acc = TM_NO_ACCESS;
      case (st)
         ST_STOP:  acc = '{cs: 1'b1, addr: TM_ADDR_CONTROL, data: CMD_STOP};
         ST_P0:    acc = '{cs: 1'b1, addr: TM_ADDR_PERIOD0, data: period[15:0]};
         ST_P1:    acc = '{cs: 1'b1, addr: TM_ADDR_PERIOD1, data: period[31:16]};
         ST_P2:    acc = '{cs: 1'b1, addr: TM_ADDR_PERIOD2, data: 16'h0000};
         ST_P3:    acc = '{cs: 1'b1, addr: TM_ADDR_PERIOD3, data: 16'h0000};
         ST_START: acc = '{cs: 1'b1, addr: TM_ADDR_CONTROL, data: CMD_START};
         ST_CLEAR: acc = '{cs: 1'b1, addr: TM_ADDR_STATUS,  data: 16'h0000};
         default:  acc = TM_NO_ACCESS;
      endcase
      return acc;
   endfunction

endpackage

// File: rtl/timer_sched_ctrl_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The requester just after the last granted index has
// the highest priority; after reset index 0 is highest.
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   req_i           - request vector
//   advance_i       - grant is taken this cycle; move the priority pointer
//   grant_o         - one-hot grant (combinational from req_i and pointer)
//   grant_idx_o     - binary index of the grant
//   grant_valid_o   - some request is being granted
module rr_arbiter
   import timer_sched_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req_i,
   input  logic             advance_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_valid_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int               scan_idx;
   int               next_idx;

   // Scan from the pointer upward with wrap; the inner loop keeps every
   // bit select constant so the index never needs a variable width.
   always_comb begin
      grant_o       = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      scan_idx      = 0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = int'(ptr_q) + i;
         if (scan_idx >= NREQ) begin
            scan_idx = scan_idx - NREQ;
         end
         for (int j = 0; j < NREQ; j++) begin
            if (!grant_valid_o && (j == scan_idx) && req_i[j]) begin
               grant_o[j]    = 1'b1;
               grant_idx_o   = IDX_W'(j);
               grant_valid_o = 1'b1;
            end
         end
      end
   end

   always_comb begin
      next_idx = int'(grant_idx_o) + 1;
      if (next_idx >= NREQ) begin
         next_idx = 0;
      end
      ptr_d = ptr_q;
      if (advance_i && grant_valid_o) begin
         ptr_d = IDX_W'(next_idx);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/timer_sched_ctrl.sv
// timer_sched_ctrl
// Shares one hardware interval timer among NREQ requesters. A granted
// request programs the timer as a one-shot, waits for its interrupt,
// clears it and pulses req_done_o for the owner.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   req_valid_i        - per-requester timeout request
//   req_period_i       - per-requester 32-bit period, slice i = [32i+31:32i]
//   req_ready_o        - one-hot, high in the accept cycle
//   req_done_o         - one-hot, one-cycle pulse when the timeout expires
//   busy_o             - controller is not idle
//   tm_address_o       - timer slave halfword register address
//   tm_chipselect_o    - timer slave select
//   tm_write_n_o       - timer slave write strobe, active-low
//   tm_writedata_o     - timer slave write data
//   tm_irq_i           - timer interrupt, level, held until status write
module timer_sched_ctrl
   import timer_sched_ctrl_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [32*NREQ-1:0]   req_period_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic [NREQ-1:0]      req_done_o,
   output logic                 busy_o,
   output logic [3:0]           tm_address_o,
   output logic                 tm_chipselect_o,
   output logic                 tm_write_n_o,
   output logic [15:0]          tm_writedata_o,
   input  logic                 tm_irq_i
);

   localparam int IDX_W = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [31:0]      period_q, period_d;
   tm_access_t       tm_q, tm_d;
   logic             irq_q;

   logic [NREQ-1:0]  arb_grant;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;
   logic             arb_advance;
   logic [31:0]      sel_period;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arbiter (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_i         (req_valid_i),
      .advance_i     (arb_advance),
      .grant_o       (arb_grant),
      .grant_idx_o   (arb_idx),
      .grant_valid_o (arb_valid)
   );

   always_comb begin
      sel_period = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            sel_period = req_period_i[32*i +: 32];
         end
      end
   end

   // Grants are also masked by reset_n so req_ready_o stays low while reset
   // is held, even if requesters keep their valids up.
   // The timer access for a state is computed from the next state and
   // registered, so tm_* appear in the same cycle as that state and never
   // depend combinationally on req_valid_i.
   always_comb begin
      state_d     = state_q;
      gnt_idx_d   = gnt_idx_q;
      period_d    = period_q;
      req_ready_o = '0;
      arb_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid && reset_n) begin
               arb_advance = 1'b1;
               req_ready_o = arb_grant;
               gnt_idx_d   = arb_idx;
               period_d    = sel_period;
               state_d     = (sel_period == 32'd0) ? ST_DONE : ST_STOP;
            end
         end
         ST_STOP:  state_d = ST_P0;
         ST_P0:    state_d = ST_P1;
         ST_P1:    state_d = ST_P2;
         ST_P2:    state_d = ST_P3;
         ST_P3:    state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (irq_q) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      tm_d = tm_access_for(state_d, period_d);
   end

   // irq is registered before the WAIT decision; it is only looked at in
   // WAIT, so a stale level in IDLE, CLEAR or DONE has no effect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         gnt_idx_q <= '0;
         period_q  <= '0;
         tm_q      <= TM_NO_ACCESS;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         period_q  <= period_d;
         tm_q      <= tm_d;
         irq_q     <= tm_irq_i;
      end
   end

   always_comb begin
      req_done_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         if ((state_q == ST_DONE) && (int'(gnt_idx_q) == i)) begin
            req_done_o[i] = 1'b1;
         end
      end
   end

   assign busy_o          = (state_q != ST_IDLE);
   assign tm_chipselect_o = tm_q.cs;
   assign tm_write_n_o    = ~tm_q.cs;
   assign tm_address_o    = tm_q.addr;
   assign tm_writedata_o  = tm_q.data;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// tb_timer_sched_ctrl
// Directed self-checking bench for timer_sched_ctrl with a small
// behavioural model of the timer slave that raises tm_irq period+2 cycles
// after a START write and drops it on a status write.
module tb_timer_sched_ctrl;

   localparam int NREQ = 4;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_period = '0;
   logic [3:0]   req_ready;
   logic [3:0]   req_done;
   logic         busy;
   logic [3:0]   tm_address;
   logic         tm_chipselect;
   logic         tm_write_n;
   logic [15:0]  tm_writedata;
   logic         tm_irq;
   logic         modelIrq = 1'b0;
   logic         irqForce = 1'b0;

   assign tm_irq = modelIrq | irqForce;

   timer_sched_ctrl #(.NREQ(NREQ)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid_i     (req_valid),
      .req_period_i    (req_period),
      .req_ready_o     (req_ready),
      .req_done_o      (req_done),
      .busy_o          (busy),
      .tm_address_o    (tm_address),
      .tm_chipselect_o (tm_chipselect),
      .tm_write_n_o    (tm_write_n),
      .tm_writedata_o  (tm_writedata),
      .tm_irq_i        (tm_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      int          c;
      logic [3:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t        wrLog[$];
   int         doneCount = 0;
   int         lastDoneCyc = 0;
   logic [3:0] lastDoneVec = '0;
   int         irqCyc = 0;
   logic       prevIrq = 1'b0;
   int         csCount = 0;
   int         busyCount = 0;
   int         oneHotErr = 0;
   int         busErr = 0;
   int         readyWithDone = 0;

   always @(negedge clk) begin
      if (tm_chipselect) begin
         wrLog.push_back('{cyc, tm_address, tm_writedata});
         csCount++;
         if (tm_write_n !== 1'b0) busErr++;
      end else if (tm_write_n !== 1'b1 || tm_address !== 4'd0 || tm_writedata !== 16'd0) begin
         busErr++;
      end
      if (req_done != 4'd0) begin
         doneCount++;
         lastDoneCyc = cyc;
         lastDoneVec = req_done;
         if (req_ready != 4'd0) readyWithDone++;
      end
      if (tm_irq && !prevIrq) irqCyc = cyc;
      prevIrq = tm_irq;
      if (busy) busyCount++;
      if ($countones(req_ready) > 1 || $countones(req_done) > 1) oneHotErr++;
   end

   // Timer slave model: a write seen during a cycle takes effect at the
   // following rising edge.
   logic [15:0] tmHalf [4];
   logic        running = 1'b0;
   int          cnt = 0;
   logic        wrSeen;
   logic [3:0]  wa;
   logic [15:0] wd;
   initial begin
      for (int i = 0; i < 4; i++) tmHalf[i] = '0;
      forever begin
         @(negedge clk);
         wrSeen = tm_chipselect && !tm_write_n;
         wa     = tm_address;
         wd     = tm_writedata;
         @(posedge clk);
         #1;
         if (!reset_n) begin
            modelIrq = 1'b0;
            running  = 1'b0;
         end else if (wrSeen) begin
            case (wa)
               4'd0: modelIrq = 1'b0;
               4'd1: begin
                  if (wd[3]) running = 1'b0;
                  if (wd[2]) begin
                     cnt     = int'({tmHalf[1], tmHalf[0]}) + 1;
                     running = 1'b1;
                  end
               end
               4'd2, 4'd3, 4'd4, 4'd5: tmHalf[2'(wa - 4'd2)] = wd;
               default: ;
            endcase
         end else if (running) begin
            cnt--;
            if (cnt == 0) begin
               modelIrq = 1'b1;
               running  = 1'b0;
            end
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] p0,
                                input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
      req_period = {p3, p2, p1, p0};
      req_valid  = valid;
   endtask

   task automatic waitReady(input int budget, output logic [3:0] vec, output int c);
      vec = '0;
      c   = cyc;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (req_ready != 4'd0) begin
            vec = req_ready;
            c   = cyc;
            return;
         end
      end
   endtask

   task automatic waitDone(input int target, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         #2;
         if (doneCount >= target) return;
      end
   endtask

   task automatic checkResetOutputs(input string pfx);
      checkOutput({pfx, "_busy"},  32'(busy), 32'd0);
      checkOutput({pfx, "_ready"}, 32'(req_ready), 32'd0);
      checkOutput({pfx, "_done"},  32'(req_done), 32'd0);
      checkOutput({pfx, "_cs"},    32'(tm_chipselect), 32'd0);
      checkOutput({pfx, "_wrn"},   32'(tm_write_n), 32'd1);
      checkOutput({pfx, "_addr"},  32'(tm_address), 32'd0);
      checkOutput({pfx, "_data"},  32'(tm_writedata), 32'd0);
   endtask

   logic [3:0]  expAddr [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0};
   logic [15:0] expData [7] = '{16'h0008, 16'h000A, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0000};

   initial begin
      logic [3:0] vec;
      int         acc, accB, base, csBase, busyBase;

      // Reset values
      reset_n = 1'b0;
      #12;
      checkResetOutputs("rst");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single request on index 1, period 10; inputs change after accept
      wrLog.delete();
      applyStimulus(4'b0010, 32'd0, 32'd10, 32'd0, 32'd0);
      waitReady(5, vec, acc);
      checkOutput("t2_ready", 32'(vec), 32'h2);
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      req_period[32 +: 32] = 32'd99;
      waitDone(1, 80);
      checkOutput("t2_doneCount", 32'(doneCount), 32'd1);
      checkOutput("t2_doneVec", 32'(lastDoneVec), 32'h2);
      checkOutput("t2_nWrites", 32'(wrLog.size()), 32'd7);
      if (wrLog.size() >= 7) begin
         for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("t2_addr%0d", i), 32'(wrLog[i].a), 32'(expAddr[i]));
            checkOutput($sformatf("t2_data%0d", i), 32'(wrLog[i].d), 32'(expData[i]));
         end
         checkOutput("t2_accToStop", 32'(wrLog[0].c - acc), 32'd1);
         checkOutput("t2_accToStart", 32'(wrLog[5].c - acc), 32'd6);
         checkOutput("t2_startToIrq", 32'(irqCyc - wrLog[5].c), 32'd12);
         checkOutput("t2_irqToClear", 32'(wrLog[6].c - irqCyc), 32'd2);
      end
      checkOutput("t2_irqToDone", 32'(lastDoneCyc - irqCyc), 32'd3);
      checkOutput("t2_accToDone", 32'(lastDoneCyc - acc), 32'd21);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t2_singlePulse", 32'(doneCount), 32'd1);
      checkOutput("t2_idle", 32'(busy), 32'd0);

      // Round robin after index 1: requests 0 and 3 -> 3 first, 0 waits for IDLE
      applyStimulus(4'b1001, 32'd0, 32'd0, 32'd0, 32'd0);
      waitReady(5, vec, acc);
      checkOutput("t3_ready3", 32'(vec), 32'h8);
      @(posedge clk);
      #1;
      req_valid = 4'b0001;
      waitReady(6, vec, accB);
      checkOutput("t3_ready0", 32'(vec), 32'h1);
      checkOutput("t3_gap", 32'(accB - acc), 32'd2);
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      waitDone(3, 10);
      checkOutput("t3_doneCount", 32'(doneCount), 32'd3);
      checkOutput("t3_doneVec", 32'(lastDoneVec), 32'h1);
      checkOutput("t3_doneLat", 32'(lastDoneCyc - accB), 32'd1);

      // Period 0 on index 2: done the cycle after accept, timer untouched
      csBase = csCount;
      base   = doneCount;
      applyStimulus(4'b0100, 32'd0, 32'd0, 32'd0, 32'd0);
      waitReady(5, vec, acc);
      checkOutput("t4_ready", 32'(vec), 32'h4);
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      waitDone(base + 1, 10);
      checkOutput("t4_doneVec", 32'(lastDoneVec), 32'h4);
      checkOutput("t4_doneLat", 32'(lastDoneCyc - acc), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("t4_noCs", 32'(csCount - csBase), 32'd0);

      // Stale irq while idle
      csBase   = csCount;
      busyBase = busyCount;
      irqForce = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t5_noCs", 32'(csCount - csBase), 32'd0);
      checkOutput("t5_noBusy", 32'(busyCount - busyBase), 32'd0);
      irqForce = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // All four at once after reset, period 5 each -> order 0,1,2,3
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      base = doneCount;
      applyStimulus(4'b1111, 32'd5, 32'd5, 32'd5, 32'd5);
      for (int k = 0; k < 4; k++) begin
         waitReady(60, vec, acc);
         checkOutput($sformatf("t6_ready%0d", k), 32'(vec), 32'(1 << k));
         checkOutput($sformatf("t6_donesBefore%0d", k), 32'(doneCount - base), 32'(k));
         @(posedge clk);
         #1;
         req_valid[k] = 1'b0;
      end
      waitDone(base + 4, 60);
      checkOutput("t6_doneCount", 32'(doneCount - base), 32'd4);
      checkOutput("t6_lastDone", 32'(lastDoneVec), 32'h8);

      // Long period crossing the halfword boundary
      wrLog.delete();
      base = doneCount;
      applyStimulus(4'b0010, 32'd0, 32'h0001_0000, 32'd0, 32'd0);
      waitReady(5, vec, acc);
      checkOutput("t7_ready", 32'(vec), 32'h2);
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      waitDone(base + 1, 70000);
      checkOutput("t7_doneVec", 32'(lastDoneVec), 32'h2);
      checkOutput("t7_accToDone", 32'(lastDoneCyc - acc), 32'd65547);
      if (wrLog.size() >= 3) begin
         checkOutput("t7_p0", 32'(wrLog[1].d), 32'h0000);
         checkOutput("t7_p1", 32'(wrLog[2].d), 32'h0001);
      end else begin
         checkOutput("t7_nWrites", 32'(wrLog.size()), 32'd7);
      end

      // Reset during WAIT abandons the job and resets the pointer
      applyStimulus(4'b0100, 32'd0, 32'd0, 32'd50, 32'd0);
      waitReady(5, vec, acc);
      checkOutput("t8_ready", 32'(vec), 32'h4);
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t8_busyBefore", 32'(busy), 32'd1);
      base = doneCount;
      #2 reset_n = 1'b0;
      #1;
      checkResetOutputs("t8");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (70) @(posedge clk);
      #1;
      checkOutput("t8_noDone", 32'(doneCount - base), 32'd0);
      applyStimulus(4'b1001, 32'd0, 32'd0, 32'd0, 32'd0);
      waitReady(5, vec, acc);
      checkOutput("t8_ptrReset", 32'(vec), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      repeat (4) @(posedge clk);
      #1;

      checkOutput("oneHot", 32'(oneHotErr), 32'd0);
      checkOutput("busIdleValues", 32'(busErr), 32'd0);
      checkOutput("readyWithDone", 32'(readyWithDone), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_sched_ctrl.md
TIMER_SCHED_CTRL -- requirements
Module: timer_sched_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  NREQ  per-requester timeout request.
REQ-005 req_period  input  32*NREQ  per-requester period; slice i = bits [32i+31:32i].
REQ-006 req_ready  output  NREQ  one-hot; high in the cycle request i is accepted.
REQ-007 req_done  output  NREQ  one-hot, one-cycle pulse when requester i's timeout expires.
REQ-008 busy  output  1  high whenever FSM is not IDLE.
REQ-009 tm_address  output  4  timer slave register address (halfword index).
REQ-010 tm_chipselect  output  1  timer slave select.
REQ-011 tm_write_n  output  1  timer slave write strobe, active-low.
REQ-012 tm_writedata  output  16  timer slave write data.
REQ-013 tm_irq  input  1  timer interrupt, level, held until status write.

Function
REQ-014 Timer map: addr0 status (any write clears timeout), addr1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), addr2..5 period halfwords 0..3.
REQ-015 States: IDLE, STOP, P0, P1, P2, P3, START, WAIT, CLEAR, DONE.
REQ-016 IDLE: if any req_valid, grant via round-robin (priority starts after last granted index; after reset index 0 highest); assert req_ready[g] same cycle; latch g and period; go to STOP.
REQ-017 STOP: write addr1 = 16'h0008; go to P0.
REQ-018 P0..P3: write addr2..5 = period[15:0], period[31:16], 16'h0000, 16'h0000 in consecutive cycles.
REQ-019 START: write addr1 = 16'h0005 (START|ITO, one-shot); go to WAIT.
REQ-020 WAIT: remain until tm_irq sampled high; then CLEAR.
REQ-021 CLEAR: write addr0 = 16'h0000; go to DONE.
REQ-022 DONE: pulse req_done[g] one cycle; return to IDLE; tm_irq not sampled in CLEAR or DONE.
REQ-023 Each timer access is one cycle: tm_chipselect=1, tm_write_n=0; outside write states tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0.
REQ-024 Latency: accept-to-START = 6 cycles; START write to tm_irq = latched period + 2 cycles (timer behaviour); tm_irq high to req_done = 3 cycles.
REQ-025 Period 0: skip STOP..CLEAR; go IDLE->DONE; req_done[g] pulses in the cycle after accept; timer untouched.
REQ-026 req_valid deasserted or req_period changed after accept: no effect on the job in progress.
REQ-027 New requests while busy: req_ready stays 0; request waits (held valid) until IDLE.
REQ-028 tm_irq high in IDLE (stale): ignored; no write issued.
REQ-029 Simultaneous req_done and new req_valid: new grant no earlier than the IDLE cycle after DONE.
REQ-030 Only one requester granted at a time; req_ready and req_done never have more than one bit set.

Reset
REQ-031 On reset_n low, asynchronously: FSM=IDLE, RR pointer=0, latched grant/period=0, req_ready=0, req_done=0, busy=0, tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0.
REQ-032 Reset mid-job abandons job with no req_done; timer is reset by the same reset_n.

Structure
REQ-033 Shared package holds: state enum, timer register addresses (STATUS=0, CONTROL=1, PERIOD0..3=2..5), control bit positions, STOP/START command constants.
REQ-034 One sub-module, rr_arbiter: NREQ request vector + advance enable -> one-hot grant, internal pointer registered.
REQ-035 Timer accesses driven from registered outputs; no combinational path from req_valid to tm_* outputs.

Verification
REQ-036 Single req: req_valid[1], period 32'd10 -> writes addr1=0008, 2=000A, 3=0000, 4=0000, 5=0000, 1=0005; irq 12 cycles later; addr0 write; req_done[1] 3 cycles after irq.
REQ-037 All four valid in the same cycle, period 5 each -> grants in order 0,1,2,3; each req_done before next req_ready.
REQ-038 Period 32'h0001_0000 -> addr2=0000, addr3=0001; req_done after 65538 cycles + fixed overhead.
REQ-039 Period 0 on req 2 -> req_done[2] next cycle after accept; zero tm_chipselect cycles.
REQ-040 Assert reset_n low during WAIT -> outputs reach reset values immediately; no req_done; next request after release granted to index 0 first.
REQ-041 tm_irq forced high while IDLE with no requests -> no timer writes, busy stays 0.
